// File: rtl/sqrt_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin square-root arbiter.
// Operands are ufix15_En8 and results are ufix15_En11.
package sqrt_arb_pkg;

  localparam int N_REQ      = 4;
  localparam int DW         = 15;
  localparam int SQ_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IN_FRAC    = 8;
  localparam int OUT_FRAC   = 11;
  // Tags are stored at the width of the largest supported requester count (8).
  localparam int TAG_MAX_W  = 3;

  typedef logic [TAG_MAX_W-1:0] tag_t;

  typedef struct packed {
    logic [DW-1:0] data;
    tag_t          tag;
  } rsp_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sqrt_rr_arbiter_if.sv
// Requester, datapath and response signals of the square-root arbiter.
// slave is the arbiter side, master is the requester/datapath/consumer side.
interface sqrt_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 15,
  parameter int TAG_W = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       sq_in;
  logic [DW-1:0]       sq_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic [TAG_W-1:0]    rsp_tag;

  modport master (
    output req_valid, req_data, sq_out, rsp_ready,
    input  req_ready, sq_in, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_data, sq_out, rsp_ready,
    output req_ready, sq_in, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/sqrt_rr_arbiter_rsp_fifo.sv
// Synchronous response FIFO of rsp_t with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sqrt_arb_rsp_fifo import sqrt_arb_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  rsp_t          push_data,
  input  logic          pop,
  output rsp_t          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t          mem_q [DEPTH];
  rsp_t          mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push_s, do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Next-state for storage, pointers and count.
  always_comb begin
    do_pop_s  = pop && (cnt_q != '0);
    do_push_s = push && ((cnt_q != CW'(DEPTH)) || do_pop_s);
    mem_d     = mem_q;
    if (do_push_s) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = ptr_inc(rd_q);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/sqrt_rr_arbiter.sv
// Round-robin, credit-limited sharing of one fixed-latency sqrt datapath.
// Optional per-requester grant counters: define SQRT_ARB_STATS_EN.
module sqrt_rr_arbiter #(
  parameter int N_REQ      = sqrt_arb_pkg::N_REQ,
  parameter int DW         = sqrt_arb_pkg::DW,
  parameter int SQ_LAT     = sqrt_arb_pkg::SQ_LAT,
  parameter int FIFO_DEPTH = sqrt_arb_pkg::FIFO_DEPTH,
  parameter int TAG_W      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  sqrt_rr_arbiter_if.slave   bus
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] stat_grants
`endif
);
  import sqrt_arb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [SQ_LAT-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [SQ_LAT];
  logic [TAG_W-1:0]  tag_d [SQ_LAT];
  logic [N_REQ-1:0]  grant_s;
  logic              grant_any_s;
  logic [TAG_W-1:0]  grant_idx_s;
  logic [DW-1:0]     sq_in_s;
  logic              issue_ok_s;
  logic [CW-1:0]     fifo_cnt_s;
  logic              fifo_full_s, fifo_empty_s, pop_s;
  rsp_t              push_data_s, head_s;

  // Credit: in-flight results plus buffered results must stay below the FIFO depth.
  always_comb begin
    int unsigned used;
    used = 0;
    for (int s = 0; s < SQ_LAT; s++) used = used + 32'(vld_q[s]);
    used       = used + 32'(fifo_cnt_s);
    issue_ok_s = !fifo_full_s && (used < 32'(FIFO_DEPTH));
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int idx;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    idx         = 0;
    if (issue_ok_s) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_any_s && bus.req_valid[idx]) begin
          grant_any_s = 1'b1;
          grant_idx_s = TAG_W'(idx);
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
    grant_s = grant_any_s ? (N_REQ'(1) << grant_idx_s) : '0;
    sq_in_s = grant_any_s ? bus.req_data[grant_idx_s*DW +: DW] : '0;
  end

  // Pointer and valid/tag tracking pipeline next-state.
  always_comb begin
    ptr_d    = grant_any_s ? grant_idx_s : ptr_q;
    vld_d    = '0;
    tag_d    = '{default: '0};
    vld_d[0] = grant_any_s;
    tag_d[0] = grant_idx_s;
    for (int s = 1; s < SQ_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = tag_q[s-1];
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= TAG_W'(N_REQ - 1);
      vld_q <= '0;
      for (int s = 0; s < SQ_LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign push_data_s.data = bus.sq_out;
  assign push_data_s.tag  = tag_t'(tag_q[SQ_LAT-1]);
  assign pop_s            = bus.rsp_ready && !fifo_empty_s;

  sqrt_arb_rsp_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_q[SQ_LAT-1]),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_cnt_s)
  );

  assign bus.req_ready = grant_s;
  assign bus.sq_in     = sq_in_s;
  assign bus.rsp_valid = !fifo_empty_s;
  assign bus.rsp_data  = head_s.data;
  assign bus.rsp_tag   = TAG_W'(head_s.tag);

`ifdef SQRT_ARB_STATS_EN
  logic [15:0] stat_q [N_REQ];
  logic [15:0] stat_d [N_REQ];

  // Saturating grant counters and their packed view.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        stat_d[i] = sat_inc16(stat_q[i]);
      end else begin
        stat_d[i] = stat_q[i];
      end
      stat_grants[i*16 +: 16] = stat_q[i];
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end
`endif
endmodule

// File: tb/tb_sqrt_rr_arbiter.sv
// Directed bench for sqrt_rr_arbiter with a sq_in+1, two-cycle datapath model.
// Build with SQRT_ARB_STATS_EN defined to also exercise the grant counters.
module tb_sqrt_rr_arbiter;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   n_grants;
  logic [1:0]  pop_tags [$];
  logic [14:0] pop_data [$];
  logic [14:0] core_d1, core_d2;
`ifdef SQRT_ARB_STATS_EN
  logic [63:0] stat_grants;
`endif

  sqrt_rr_arbiter_if #(.N_REQ(4), .DW(15), .TAG_W(2)) bus ();

  sqrt_rr_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SQRT_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: result = operand + 1, two cycles later, reset with the arbiter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_d1 <= '0;
      core_d2 <= '0;
    end else begin
      core_d1 <= bus.sq_in + 15'd1;
      core_d2 <= core_d1;
    end
  end
  assign bus.sq_out = core_d2;

  typedef struct {
    logic [3:0]  v;
    logic        rr;
    logic [3:0]  g;
    logic [14:0] sq;
    logic        rv;
    logic [14:0] rd;
    logic [1:0]  rt;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [14:0] exp_rsp(input logic [1:0] t);
    case (t)
      2'd0:    return 15'h0101;
      2'd1:    return 15'h0201;
      2'd2:    return 15'h0301;
      default: return 15'h0401;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic rr);
    @(negedge clk);
    bus.req_valid = v;
    bus.rsp_ready = rr;
    #1;
    if (bus.req_ready != 4'b0000) n_grants++;
    if (bus.rsp_valid && rr) begin
      pop_tags.push_back(bus.rsp_tag);
      pop_data.push_back(bus.rsp_data);
    end
  endtask

  task automatic check_pops(input string nm, input int n, input logic [15:0] tags);
    logic [1:0] t;
    chk({nm, "_count"}, 32'(pop_tags.size()), 32'(n));
    for (int k = 0; k < n && k < int'(pop_tags.size()); k++) begin
      t = tags[2*k +: 2];
      chk($sformatf("%s_tag%0d", nm, k), 32'(pop_tags[k]), 32'(t));
      chk($sformatf("%s_data%0d", nm, k), 32'(pop_data[k]), 32'(exp_rsp(t)));
    end
    pop_tags.delete();
    pop_data.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    n_grants      = 0;
    reset         = 1'b1;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    bus.req_data  = {15'h0400, 15'h0300, 15'h0200, 15'h0100};

    // {valid, rsp_ready, grant, sq_in, rsp_valid, rsp_data, rsp_tag}
    tbl[0]  = '{4'h1, 1'b1, 4'h1, 15'h0100, 1'b0, 15'h0000, 2'd0};
    tbl[1]  = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b0, 15'h0000, 2'd0};
    tbl[2]  = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b0, 15'h0000, 2'd0};
    tbl[3]  = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b1, 15'h0101, 2'd0};
    tbl[4]  = '{4'hF, 1'b1, 4'h2, 15'h0200, 1'b0, 15'h0000, 2'd0};
    tbl[5]  = '{4'hF, 1'b1, 4'h4, 15'h0300, 1'b0, 15'h0000, 2'd0};
    tbl[6]  = '{4'hF, 1'b1, 4'h8, 15'h0400, 1'b0, 15'h0000, 2'd0};
    tbl[7]  = '{4'hF, 1'b1, 4'h1, 15'h0100, 1'b1, 15'h0201, 2'd1};
    tbl[8]  = '{4'hF, 1'b1, 4'h2, 15'h0200, 1'b1, 15'h0301, 2'd2};
    tbl[9]  = '{4'hF, 1'b1, 4'h4, 15'h0300, 1'b1, 15'h0401, 2'd3};
    tbl[10] = '{4'hF, 1'b1, 4'h8, 15'h0400, 1'b1, 15'h0101, 2'd0};
    tbl[11] = '{4'hF, 1'b1, 4'h1, 15'h0100, 1'b1, 15'h0201, 2'd1};
    tbl[12] = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b1, 15'h0301, 2'd2};
    tbl[13] = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b1, 15'h0401, 2'd3};
    tbl[14] = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b1, 15'h0101, 2'd0};
    tbl[15] = '{4'h0, 1'b1, 4'h0, 15'h0000, 1'b0, 15'h0000, 2'd0};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request, then continuous round-robin with rsp_ready high.
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, tbl[i].rr);
      chk($sformatf("tbl%0d_grant", i), 32'(bus.req_ready), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_sq_in", i), 32'(bus.sq_in), 32'(tbl[i].sq));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_rsp_data", i), 32'(bus.rsp_data), 32'(tbl[i].rd));
        chk($sformatf("tbl%0d_rsp_tag", i), 32'(bus.rsp_tag), 32'(tbl[i].rt));
      end
    end
    pop_tags.delete();
    pop_data.delete();

    // Backpressure: credits run out after exactly FIFO_DEPTH grants.
    n_grants = 0;
    repeat (8) cyc(4'hF, 1'b0);
    chk("bp_grants", 32'(n_grants), 32'd4);
    chk("bp_stalled_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    cyc(4'hF, 1'b1);
    chk("bp_pop_not_credited", 32'(bus.req_ready), 32'd0);
    cyc(4'hF, 1'b1);
    chk("bp_resume_grant", 32'(bus.req_ready), 32'h2);
    repeat (8) cyc(4'h0, 1'b1);
    check_pops("bp_drain", 5, {6'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1});

    // Three buffered, one arriving, pop on its arrival cycle.
    repeat (4) cyc(4'hF, 1'b0);
    cyc(4'hF, 1'b0);
    chk("full_no_credit", 32'(bus.req_ready), 32'd0);
    cyc(4'h0, 1'b1);
    cyc(4'h0, 1'b0);
    chk("full_head_valid", 32'(bus.rsp_valid), 32'd1);
    chk("full_head_tag", 32'(bus.rsp_tag), 32'd3);
    repeat (6) cyc(4'h0, 1'b1);
    check_pops("full_drain", 4, {8'd0, 2'd1, 2'd0, 2'd3, 2'd2});

    // Reset with two in flight and two buffered.
    repeat (4) cyc(4'hF, 1'b0);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("midrst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pop_tags.delete();
    pop_data.delete();
    cyc(4'hF, 1'b1);
    chk("midrst_first_grant", 32'(bus.req_ready), 32'h1);
    repeat (8) cyc(4'h0, 1'b1);
    check_pops("midrst_drain", 1, 16'd0);

`ifdef SQRT_ARB_STATS_EN
    repeat (70000) cyc(4'h2, 1'b1);
    chk("stats_req1_saturated", 32'(stat_grants[31:16]), 32'hFFFF);
    chk("stats_req0", 32'(stat_grants[15:0]), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
